// File: rtl/oat_hash_pkg.sv
// Shared constants and mixing functions for the one-at-a-time hash pipeline.
package oat_hash_pkg;

   localparam int OAT_HASH_W = 32;

   // Integer ceiling division, used to size the number of mix stages.
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Fold one key byte into the running hash.
   function automatic logic [OAT_HASH_W-1:0] oat_mix_byte(input logic [OAT_HASH_W-1:0] h,
                                                          input logic [7:0]            b);
      logic [OAT_HASH_W-1:0] x;
      x = h + {24'd0, b};
      x = x + (x << 10);
      x = x ^ (x >> 6);
      return x;
   endfunction

   // Final avalanche applied once all key bytes are mixed.
   function automatic logic [OAT_HASH_W-1:0] oat_final(input logic [OAT_HASH_W-1:0] h);
      logic [OAT_HASH_W-1:0] x;
      x = h + (h << 3);
      x = x ^ (x >> 11);
      x = x + (x << 15);
      return x;
   endfunction

endpackage

// File: rtl/oat_hash_stage.sv
// One mix stage: folds BYTES_IN_STAGE leading key bytes into the hash and
// registers the hash, valid, tag and the still-unconsumed key bytes.
module oat_hash_stage
   import oat_hash_pkg::*;
#(
   parameter  int BYTES_IN_STAGE = 1,
   parameter  int REM_BYTES      = 6,
   parameter  int TAG_WIDTH      = 8,
   localparam int KEEP_BYTES     = REM_BYTES - BYTES_IN_STAGE,
   localparam int KEY_O_BYTES    = (KEEP_BYTES > 0) ? KEEP_BYTES : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     valid_i,
   input  logic [OAT_HASH_W-1:0]    hash_i,
   input  logic [8*REM_BYTES-1:0]   key_i,
   input  logic [TAG_WIDTH-1:0]     tag_i,
   output logic                     valid_o,
   output logic [OAT_HASH_W-1:0]    hash_o,
   output logic [8*KEY_O_BYTES-1:0] key_o,
   output logic [TAG_WIDTH-1:0]     tag_o
);

   logic                  valid_q;
   logic [OAT_HASH_W-1:0] hash_q;
   logic [OAT_HASH_W-1:0] hash_d;
   logic [TAG_WIDTH-1:0]  tag_q;

   // Mix this stage's bytes in ascending byte order (MSB end of key first).
   always_comb begin
      hash_d = hash_i;
      for (int unsigned i = 0; i < BYTES_IN_STAGE; i++) begin
         hash_d = oat_mix_byte(hash_d, key_i[8*(REM_BYTES-1-i) +: 8]);
      end
   end

   // Stage register: reset clears everything, otherwise advance only on enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         hash_q  <= '0;
         tag_q   <= '0;
      end else if (en) begin
         valid_q <= valid_i;
         hash_q  <= hash_d;
         tag_q   <= tag_i;
      end
   end

   // Consumed bytes are dropped; the last stage has no key left to carry.
   if (KEEP_BYTES > 0) begin : g_key
      logic [8*KEEP_BYTES-1:0] key_q;

      // Carry the unconsumed low-order key bytes to the next stage.
      always_ff @(posedge clk) begin
         if (reset) begin
            key_q <= '0;
         end else if (en) begin
            key_q <= key_i[8*KEEP_BYTES-1:0];
         end
      end

      assign key_o = key_q;
   end else begin : g_no_key
      assign key_o = '0;
   end

   assign valid_o = valid_q;
   assign hash_o  = hash_q;
   assign tag_o   = tag_q;

endmodule

// File: rtl/oat_hash_pipe.sv
// Fully pipelined Jenkins one-at-a-time hash with valid/ready flow control,
// programmable seed, pass-through tag and table-index output.
module oat_hash_pipe
   import oat_hash_pkg::*;
#(
   parameter int NUM_BYTES       = 6,
   parameter int BYTES_PER_STAGE = 1,
   parameter int TAG_WIDTH       = 8,
   parameter int INDEX_BITS      = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*NUM_BYTES-1:0]  in_key,
   input  logic [OAT_HASH_W-1:0]   in_seed,
   input  logic [TAG_WIDTH-1:0]    in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OAT_HASH_W-1:0]   out_hash,
   output logic [INDEX_BITS-1:0]   out_index,
   output logic [TAG_WIDTH-1:0]    out_tag
);

   localparam int MIX_STAGES = ceil_div(NUM_BYTES, BYTES_PER_STAGE);
   localparam int KEY_W      = 8*NUM_BYTES;

   logic                  en;
   logic                  v_s [0:MIX_STAGES];
   logic [OAT_HASH_W-1:0] h_s [0:MIX_STAGES];
   logic [TAG_WIDTH-1:0]  t_s [0:MIX_STAGES];
   logic [KEY_W-1:0]      k_s [0:MIX_STAGES];

   logic                  out_valid_q;
   logic [OAT_HASH_W-1:0] out_hash_q;
   logic [OAT_HASH_W-1:0] out_hash_d;
   logic [TAG_WIDTH-1:0]  out_tag_q;

   // Single global enable: the whole pipe advances or holds together.
   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   assign v_s[0] = in_valid;
   assign h_s[0] = in_seed;
   assign t_s[0] = in_tag;
   assign k_s[0] = in_key;

   // Remaining key bytes are kept right-aligned in k_s; unused upper bits are tied off.
   for (genvar k = 0; k < MIX_STAGES; k++) begin : g_mix
      localparam int REM = NUM_BYTES - k*BYTES_PER_STAGE;
      localparam int BIS = (REM < BYTES_PER_STAGE) ? REM : BYTES_PER_STAGE;
      localparam int KO  = (REM > BIS) ? REM - BIS : 1;

      oat_hash_stage #(
         .BYTES_IN_STAGE (BIS),
         .REM_BYTES      (REM),
         .TAG_WIDTH      (TAG_WIDTH)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .en      (en),
         .valid_i (v_s[k]),
         .hash_i  (h_s[k]),
         .key_i   (k_s[k][8*REM-1:0]),
         .tag_i   (t_s[k]),
         .valid_o (v_s[k+1]),
         .hash_o  (h_s[k+1]),
         .key_o   (k_s[k+1][8*KO-1:0]),
         .tag_o   (t_s[k+1])
      );

      if (KO < NUM_BYTES) begin : g_pad
         assign k_s[k+1][KEY_W-1:8*KO] = '0;
      end
   end

   // Final avalanche of the fully mixed hash.
   always_comb begin
      out_hash_d = oat_final(h_s[MIX_STAGES]);
   end

   // Output register: holds under backpressure, reset takes priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_hash_q  <= '0;
         out_tag_q   <= '0;
      end else if (en) begin
         out_valid_q <= v_s[MIX_STAGES];
         out_hash_q  <= out_hash_d;
         out_tag_q   <= t_s[MIX_STAGES];
      end
   end

   assign out_valid = out_valid_q;
   assign out_hash  = out_hash_q;
   assign out_index = out_hash_q[INDEX_BITS-1:0];
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_oat_hash_pipe.sv
// Scoreboard bench for oat_hash_pipe in three configurations:
// 1-byte keys, 6-byte keys (main flow-control tests) and 43-byte keys, 4 bytes/stage.
module tb_oat_hash_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int unsigned cyc = 0;
   int          pass_cnt = 0;
   int          chk_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] h;
      logic [7:0]  tag;
      int unsigned cyc;
   } exp_t;

   // 1-byte instance
   logic        v1 = 1'b0, r1, or1 = 1'b1, ov1;
   logic [7:0]  k1 = '0, t1 = '0, ot1;
   logic [31:0] s1 = '0, oh1;
   logic [9:0]  oi1;
   exp_t        q1[$];
   exp_t        e1;

   // 6-byte instance
   logic        v6 = 1'b0, r6, or6 = 1'b1, ov6;
   logic [47:0] k6 = '0;
   logic [7:0]  t6 = '0, ot6;
   logic [31:0] s6 = '0, oh6;
   logic [9:0]  oi6;
   exp_t        q6[$];
   exp_t        e6;
   bit          rnd6 = 1'b0;
   bit          lat_en6 = 1'b1;
   bit          held6 = 1'b0;
   logic [31:0] h_hold6;
   logic [7:0]  t_hold6;

   // 43-byte instance
   logic         v43 = 1'b0, r43, or43 = 1'b1, ov43;
   logic [343:0] k43 = '0;
   logic [7:0]   t43 = '0, ot43;
   logic [31:0]  s43 = '0, oh43;
   logic [9:0]   oi43;
   exp_t         q43[$];
   exp_t         e43;

   oat_hash_pipe #(.NUM_BYTES(1), .BYTES_PER_STAGE(1), .TAG_WIDTH(8), .INDEX_BITS(10)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1), .in_key(k1), .in_seed(s1),
      .in_tag(t1), .out_valid(ov1), .out_ready(or1), .out_hash(oh1), .out_index(oi1), .out_tag(ot1));

   oat_hash_pipe #(.NUM_BYTES(6), .BYTES_PER_STAGE(1), .TAG_WIDTH(8), .INDEX_BITS(10)) u_dut6 (
      .clk(clk), .reset(reset), .in_valid(v6), .in_ready(r6), .in_key(k6), .in_seed(s6),
      .in_tag(t6), .out_valid(ov6), .out_ready(or6), .out_hash(oh6), .out_index(oi6), .out_tag(ot6));

   oat_hash_pipe #(.NUM_BYTES(43), .BYTES_PER_STAGE(4), .TAG_WIDTH(8), .INDEX_BITS(10)) u_dut43 (
      .clk(clk), .reset(reset), .in_valid(v43), .in_ready(r43), .in_key(k43), .in_seed(s43),
      .in_tag(t43), .out_valid(ov43), .out_ready(or43), .out_hash(oh43), .out_index(oi43), .out_tag(ot43));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference one-at-a-time hash over n bytes, byte 0 at the MSB end of key.
   function automatic logic [31:0] oat_ref(input logic [511:0] key, input int n, input logic [31:0] seed);
      logic [31:0] h;
      h = seed;
      for (int i = 0; i < n; i++) begin
         h = h + {24'd0, key[8*(n-1-i) +: 8]};
         h = h + (h << 10);
         h = h ^ (h >> 6);
      end
      h = h + (h << 3);
      h = h ^ (h >> 11);
      h = h + (h << 15);
      return h;
   endfunction

   // Monitors: compare every delivered result with the head of its queue.
   always @(negedge clk) begin
      if (reset) begin
         q1.delete();
      end else if (ov1 && or1) begin
         if (q1.size() == 0) chk("unexpected_out1", ov1, 0);
         else begin
            e1 = q1.pop_front();
            chk("hash1", oh1, e1.h);
            chk("index1", oi1, e1.h[9:0]);
            chk("tag1", ot1, e1.tag);
            chk("latency1", cyc - e1.cyc, 2);
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         q43.delete();
      end else if (ov43 && or43) begin
         if (q43.size() == 0) chk("unexpected_out43", ov43, 0);
         else begin
            e43 = q43.pop_front();
            chk("hash43", oh43, e43.h);
            chk("index43", oi43, e43.h[9:0]);
            chk("tag43", ot43, e43.tag);
            chk("latency43", cyc - e43.cyc, 12);
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         q6.delete();
         held6 = 1'b0;
      end else begin
         chk("in_ready6", r6, !ov6 || or6);
         if (held6) begin
            chk("hold_valid6", ov6, 1);
            chk("hold_hash6", oh6, h_hold6);
            chk("hold_tag6", ot6, t_hold6);
         end
         held6   = ov6 && !or6;
         h_hold6 = oh6;
         t_hold6 = ot6;
         if (ov6 && or6) begin
            if (q6.size() == 0) chk("unexpected_out6", ov6, 0);
            else begin
               e6 = q6.pop_front();
               chk("hash6", oh6, e6.h);
               chk("index6", oi6, e6.h[9:0]);
               chk("tag6", ot6, e6.tag);
               if (lat_en6) chk("latency6", cyc - e6.cyc, 7);
            end
         end
      end
   end

   // Present a key to the 6-byte engine, hold it until taken, record expectation.
   task automatic send6(input logic [47:0] k, input logic [31:0] s, input logic [7:0] t,
                        input logic [31:0] eh);
      bit acc = 1'b0;
      v6 = 1'b1; k6 = k; s6 = s; t6 = t;
      for (int n = 0; n < 100 && !acc; n++) begin
         @(negedge clk);
         acc = r6;
         if (acc) q6.push_back('{eh, t, cyc});
         @(posedge clk); #1;
         if (rnd6) or6 = 1'($urandom_range(0, 1));
      end
      if (!acc) begin
         chk_cnt++;
         $display("FAIL send6_timeout: key 0x%0h not accepted, required within 100 cycles", k);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 400; n++) begin
         if (q1.size() == 0 && q6.size() == 0 && q43.size() == 0) return;
         @(posedge clk); #1;
      end
      chk_cnt++;
      $display("FAIL drain_timeout: q1=%0d q6=%0d q43=%0d left, required 0", q1.size(), q6.size(), q43.size());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [47:0] rk;
      logic [31:0] rs;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_valid6", ov6, 0);
      chk("rst_hash6", oh6, 0);
      chk("rst_index6", oi6, 0);
      chk("rst_tag6", ot6, 0);
      chk("rst_ready6", r6, 1);
      chk("rst_valid1", ov1, 0);
      chk("rst_valid43", ov43, 0);
      @(posedge clk); #1;

      // Directed: "a" on the 1-byte engine, the fox sentence on the 43-byte engine
      v1 = 1'b1; k1 = 8'h61; s1 = 32'h0; t1 = 8'h5A;
      v43 = 1'b1; k43 = "The quick brown fox jumps over the lazy dog"; s43 = 32'h0; t43 = 8'h43;
      @(negedge clk);
      chk("dir_ready1", r1, 1);
      chk("dir_ready43", r43, 1);
      if (r1) q1.push_back('{32'hCA2E9442, 8'h5A, cyc});
      if (r43) q43.push_back('{32'h519E91F5, 8'h43, cyc});
      @(posedge clk); #1;
      v1 = 1'b0; v43 = 1'b0;

      // Directed: zero key, seed 0 then seed 1
      send6(48'h0, 32'h0, 8'hA0, 32'h0000_0000);
      send6(48'h0, 32'h1, 8'hA1, oat_ref(512'(48'h0), 6, 32'h1));
      v6 = 1'b0;
      drain();

      // Back-to-back keys, tags 0..99, out_ready held high
      for (int i = 0; i < 100; i++) begin
         rk = {16'($urandom), 32'($urandom)};
         send6(rk, 32'h0, 8'(i), oat_ref(512'(rk), 6, 32'h0));
      end
      v6 = 1'b0;
      drain();

      // Random backpressure with in_valid continuously high
      lat_en6 = 1'b0;
      rnd6 = 1'b1;
      for (int i = 0; i < 150; i++) begin
         rk = {16'($urandom), 32'($urandom)};
         rs = $urandom;
         send6(rk, rs, 8'(i), oat_ref(512'(rk), 6, rs));
      end
      rnd6 = 1'b0;
      or6 = 1'b1;
      v6 = 1'b0;
      drain();
      lat_en6 = 1'b1;

      // Fill the pipe under stall, then reset for one cycle
      or6 = 1'b0;
      v6 = 1'b1; k6 = 48'h0123_4567_89AB; s6 = 32'h0; t6 = 8'hEE;
      repeat (12) @(posedge clk);
      #1;
      reset = 1'b1; v6 = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      or6 = 1'b1;
      @(negedge clk);
      chk("post_reset_valid6", ov6, 0);
      chk("post_reset_ready6", r6, 1);
      @(posedge clk); #1;
      send6(48'hDEAD_BEEF_CAFE, 32'h0, 8'h77, oat_ref(512'(48'hDEAD_BEEF_CAFE), 6, 32'h0));
      v6 = 1'b0;
      drain();
      repeat (15) @(posedge clk);
      #1;

      chk("final_q1_empty", q1.size(), 0);
      chk("final_q6_empty", q6.size(), 0);
      chk("final_q43_empty", q43.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
